// File: rtl/markov_pkg.sv
// -----------------------------------------------------------------------------
// markov_pkg
// Shared definitions for the Markov table merge and the table builders.
//   - state_t : FSM encoding of the merge controller (IDLE=0, READ=1, CMP=2,
//               FINISH=3), 2 bits wide.
//   - KW_DEF, CW_DEF, AW_DEF : default key, count and input address widths.
// -----------------------------------------------------------------------------
package markov_pkg;

    localparam int KW_DEF = 16;
    localparam int CW_DEF = 12;
    localparam int AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        CMP    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/markov_cnt_add.sv
// -----------------------------------------------------------------------------
// markov_cnt_add
// Combinational count adder used when two table entries with the same key are
// combined. The sum is formed at CW+1 bits; the carry out is the overflow flag.
// Configuration macro: MARKOV_MERGE_SAT_EN
//   defined   : sums above 2^CW-1 clamp to 2^CW-1
//   undefined : sums wrap modulo 2^CW
// Ports:
//   a, b  in  CW  addends
//   sum   out CW  wrapped or clamped sum
//   ovf   out 1   high when the true sum does not fit in CW bits
// -----------------------------------------------------------------------------
module markov_cnt_add #(
    parameter int CW = 12
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] sum,
    output logic          ovf
);

    logic [CW:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[CW];

`ifdef MARKOV_MERGE_SAT_EN
    assign sum = ovf ? {CW{1'b1}} : full[CW-1:0];
`else
    assign sum = full[CW-1:0];
`endif

endmodule

// File: rtl/markov_merge_n.sv
// -----------------------------------------------------------------------------
// markov_merge_n
// Merges two key-sorted (key, count) tables A and B, read from two external
// synchronous RAMs, into one key-sorted table written to an output RAM.
// Equal keys produce a single entry carrying the sum of both counts.
// Each output entry takes a READ cycle (addresses presented) followed by a
// CMP cycle (RAM data valid, one write), so start-to-done is 2*len_out+2.
//
// Configuration macro: MARKOV_MERGE_SAT_EN (saturating count add plus the
// sticky 'sat' output); default build wraps counts and has no 'sat' port.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            request, sampled only in IDLE
//   len_a, len_b     entry counts of A and B (0..2^AW), latched on start
//   a_addr/a_key/a_cnt  A RAM read port (data one cycle after address)
//   b_addr/b_key/b_cnt  B RAM read port (data one cycle after address)
//   o_we/o_addr/o_key/o_cnt  output RAM write port (2^(AW+1) entries)
//   len_out          number of entries written; valid from done, held until
//                    the next start. It is AW+2 bits wide because a merge of
//                    two full disjoint tables yields exactly 2^(AW+1) entries.
//   busy             high from the cycle after start through the done cycle
//   done             one-cycle completion pulse
//   sat              (macro only) sticky clamp indicator, cleared on start
// -----------------------------------------------------------------------------
module markov_merge_n
    import markov_pkg::*;
#(
    parameter int KW = KW_DEF,
    parameter int CW = CW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len_a,
    input  logic [AW:0]   len_b,
    output logic [AW-1:0] a_addr,
    input  logic [KW-1:0] a_key,
    input  logic [CW-1:0] a_cnt,
    output logic [AW-1:0] b_addr,
    input  logic [KW-1:0] b_key,
    input  logic [CW-1:0] b_cnt,
    output logic          o_we,
    output logic [AW:0]   o_addr,
    output logic [KW-1:0] o_key,
    output logic [CW-1:0] o_cnt,
    output logic [AW+1:0] len_out,
`ifdef MARKOV_MERGE_SAT_EN
    output logic          sat,
`endif
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0]   IN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] OUT_ONE = {{(AW+1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic [AW:0]   la;
    logic [AW:0]   lb;
    logic [AW:0]   ia;
    logic [AW:0]   ib;
    logic [AW+1:0] io;
    logic [AW+1:0] len_out_r;

    logic          a_live;
    logic          b_live;
    logic          inc_a;
    logic          inc_b;
    logic          sum_used;
    logic [CW-1:0] sum_cnt;
    logic          sum_ovf;

    assign a_live = (ia < la);
    assign b_live = (ib < lb);

    markov_cnt_add #(.CW(CW)) u_add (
        .a   (a_cnt),
        .b   (b_cnt),
        .sum (sum_cnt),
        .ovf (sum_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, write port and index-advance decisions
    always_comb begin
        state_nxt = state;
        o_we      = 1'b0;
        o_key     = '0;
        o_cnt     = '0;
        inc_a     = 1'b0;
        inc_b     = 1'b0;
        sum_used  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (!a_live && !b_live) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                o_we      = 1'b1;
                state_nxt = READ;
                if (a_live && b_live) begin
                    if (a_key < b_key) begin
                        o_key = a_key;
                        o_cnt = a_cnt;
                        inc_a = 1'b1;
                    end else if (a_key > b_key) begin
                        o_key = b_key;
                        o_cnt = b_cnt;
                        inc_b = 1'b1;
                    end else begin
                        o_key    = a_key;
                        o_cnt    = sum_cnt;
                        inc_a    = 1'b1;
                        inc_b    = 1'b1;
                        sum_used = 1'b1;
                    end
                end else if (a_live) begin
                    o_key = a_key;
                    o_cnt = a_cnt;
                    inc_a = 1'b1;
                end else begin
                    // READ never enters CMP with both tables exhausted, so
                    // this branch always has B live.
                    o_key = b_key;
                    o_cnt = b_cnt;
                    inc_b = 1'b1;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lengths, indices and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            la        <= '0;
            lb        <= '0;
            ia        <= '0;
            ib        <= '0;
            io        <= '0;
            len_out_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        la <= len_a;
                        lb <= len_b;
                        ia <= '0;
                        ib <= '0;
                        io <= '0;
                    end
                end
                CMP: begin
                    if (inc_a) ia <= ia + IN_ONE;
                    if (inc_b) ib <= ib + IN_ONE;
                    io <= io + OUT_ONE;
                end
                FINISH: begin
                    len_out_r <= io;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MARKOV_MERGE_SAT_EN
    logic sat_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (state == IDLE && start) begin
            sat_r <= 1'b0;
        end else if (sum_used && sum_ovf) begin
            sat_r <= 1'b1;
        end
    end

    assign sat = sat_r;
`endif

    // len_out must already be valid in the done cycle, before len_out_r
    // has captured io at the end of FINISH.
    assign len_out = (state == FINISH) ? io : len_out_r;
    assign a_addr  = ia[AW-1:0];
    assign b_addr  = ib[AW-1:0];
    assign o_addr  = io[AW:0];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_markov_merge_n.sv
// -----------------------------------------------------------------------------
// tb_markov_merge_n
// Bench for markov_merge_n with KW=16, CW=12, AW=8. Behavioural A/B read RAMs
// feed the DUT; a reference merge builds the expected write sequence into a
// queue and every o_we is popped and compared. Honours MARKOV_MERGE_SAT_EN.
// -----------------------------------------------------------------------------
module tb_markov_merge_n;

    localparam int KW = 16;
    localparam int CW = 12;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;
    localparam int PW = (AW + 1) + KW + CW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   len_a;
    logic [AW:0]   len_b;
    logic [AW-1:0] a_addr;
    logic [KW-1:0] a_key;
    logic [CW-1:0] a_cnt;
    logic [AW-1:0] b_addr;
    logic [KW-1:0] b_key;
    logic [CW-1:0] b_cnt;
    logic          o_we;
    logic [AW:0]   o_addr;
    logic [KW-1:0] o_key;
    logic [CW-1:0] o_cnt;
    logic [AW+1:0] len_out;
    logic          busy;
    logic          done;
`ifdef MARKOV_MERGE_SAT_EN
    logic          sat;
`endif

    logic [KW-1:0] ka [DEPTH];
    logic [CW-1:0] ca [DEPTH];
    logic [KW-1:0] kb [DEPTH];
    logic [CW-1:0] cb [DEPTH];

    logic [PW-1:0] exp_q [$];

    int n_checks;
    int n_fail;

    markov_merge_n #(.KW(KW), .CW(CW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len_a   (len_a),
        .len_b   (len_b),
        .a_addr  (a_addr),
        .a_key   (a_key),
        .a_cnt   (a_cnt),
        .b_addr  (b_addr),
        .b_key   (b_key),
        .b_cnt   (b_cnt),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_key   (o_key),
        .o_cnt   (o_cnt),
        .len_out (len_out),
`ifdef MARKOV_MERGE_SAT_EN
        .sat     (sat),
`endif
        .busy    (busy),
        .done    (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read RAMs
    always @(posedge clk) begin
        a_key <= ka[a_addr];
        a_cnt <= ca[a_addr];
        b_key <= kb[b_addr];
        b_cnt <= cb[b_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack(input int addr, input int key, input int cnt);
        logic [AW:0]   a;
        logic [KW-1:0] k;
        logic [CW-1:0] c;
        a = addr[AW:0];
        k = key[KW-1:0];
        c = cnt[CW-1:0];
        return {a, k, c};
    endfunction

    // Scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (o_we) begin
            check("write_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("write_entry", {o_addr, o_key, o_cnt}, exp_q.pop_front());
            end
        end
    end

    // Reference merge: fills exp_q, returns entry count and clamp flag
    task automatic build_expected(input int la, input int lb, output int n, output bit s);
        int ia, ib, sum;
        ia = 0; ib = 0; n = 0; s = 0;
        while (ia < la || ib < lb) begin
            if (ia < la && ib < lb && ka[ia] == kb[ib]) begin
                sum = int'(ca[ia]) + int'(cb[ib]);
                if (sum > (1 << CW) - 1) begin
`ifdef MARKOV_MERGE_SAT_EN
                    sum = (1 << CW) - 1;
                    s = 1;
`else
                    sum = sum % (1 << CW);
`endif
                end
                exp_q.push_back(pack(n, int'(ka[ia]), sum));
                ia++; ib++;
            end else if (ib >= lb || (ia < la && ka[ia] < kb[ib])) begin
                exp_q.push_back(pack(n, int'(ka[ia]), int'(ca[ia])));
                ia++;
            end else begin
                exp_q.push_back(pack(n, int'(kb[ib]), int'(cb[ib])));
                ib++;
            end
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        len_a = '0;
        len_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Full merge with latency, len_out and done/busy checks.
    // poke=1 fires a second start (with junk lengths) mid-run; it must be ignored.
    task automatic run_merge(input string name, input int la, input int lb, input bit poke);
        int n, cyc;
        bit s;
        build_expected(la, lb, n, s);
        @(posedge clk); #1;
        len_a = la[AW:0];
        len_b = lb[AW:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len_a = AW'($urandom_range(0, DEPTH - 1));
        len_b = AW'($urandom_range(0, DEPTH - 1));
        cyc = 1;
        check({name, "_busy_on"}, busy, 1);
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = (poke && cyc == 3);
        end
        start = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_latency"}, cyc, 2 * n + 2);
        check({name, "_len_out"}, len_out, n);
        check({name, "_queue_left"}, exp_q.size(), 0);
`ifdef MARKOV_MERGE_SAT_EN
        check({name, "_sat"}, sat, s);
`endif
        exp_q.delete();
        @(posedge clk); #1;
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_off"}, busy, 0);
        check({name, "_len_out_held"}, len_out, n);
    endtask

    task automatic gen_random(output int la, output int lb);
        int k;
        la = $urandom_range(0, 40);
        lb = $urandom_range(0, 40);
        k = $urandom_range(0, 3);
        for (int i = 0; i < la; i++) begin
            k += $urandom_range(1, 3);
            ka[i] = k[KW-1:0];
            ca[i] = CW'($urandom_range(0, (1 << CW) - 1));
        end
        k = $urandom_range(0, 3);
        for (int i = 0; i < lb; i++) begin
            k += $urandom_range(1, 3);
            kb[i] = k[KW-1:0];
            cb[i] = CW'($urandom_range(0, (1 << CW) - 1));
        end
    endtask

    initial begin
        int la, lb, n;
        bit s;
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ka[i] = '0; ca[i] = '0; kb[i] = '0; cb[i] = '0;
        end
        do_reset();

        // Reset state
        check("rst_o_we", o_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len_out", len_out, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_o_addr", o_addr, 0);
        check("rst_o_key", o_key, 0);
        check("rst_o_cnt", o_cnt, 0);
`ifdef MARKOV_MERGE_SAT_EN
        check("rst_sat", sat, 0);
`endif

        // Disjoint
        ka[0] = 16'd1; ca[0] = 12'd5; ka[1] = 16'd4; ca[1] = 12'd2;
        kb[0] = 16'd2; cb[0] = 12'd7;
        run_merge("disjoint", 2, 1, 0);

        // Full overlap
        ka[0] = 16'd3; ca[0] = 12'd10;
        kb[0] = 16'd3; cb[0] = 12'd20;
        run_merge("overlap", 1, 1, 0);

        // Count overflow (4000+200)
        ka[0] = 16'd9; ca[0] = 12'd4000;
        kb[0] = 16'd9; cb[0] = 12'd200;
        run_merge("overflow", 1, 1, 0);

        // Empty and one-sided
        run_merge("empty", 0, 0, 0);
        kb[0] = 16'd5; cb[0] = 12'd1; kb[1] = 16'd6; cb[1] = 12'd2;
        run_merge("b_only", 0, 2, 0);

        // 8 even / 8 odd interleave, with an ignored start while busy
        for (int i = 0; i < 8; i++) begin
            ka[i] = 16'(2 * i);     ca[i] = 12'(i + 1);
            kb[i] = 16'(2 * i + 1); cb[i] = 12'(100 + i);
        end
        run_merge("interleave", 8, 8, 1);

        // Full-capacity tables: disjoint gives 2^(AW+1) outputs, then identical keys
        for (int i = 0; i < DEPTH; i++) begin
            ka[i] = 16'(2 * i);     ca[i] = 12'(i);
            kb[i] = 16'(2 * i + 1); cb[i] = 12'(3 * i);
        end
        run_merge("full_disjoint", DEPTH, DEPTH, 0);
        for (int i = 0; i < DEPTH; i++) kb[i] = ka[i];
        run_merge("full_same", DEPTH, DEPTH, 0);

        // Reset during the third CMP: only the first three writes may appear
        for (int i = 0; i < 4; i++) begin
            ka[i] = 16'(10 * (i + 1)); ca[i] = 12'(i + 7);
        end
        build_expected(4, 0, n, s);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        len_a = 9'd4; len_b = 9'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_o_we", o_we, 0);
        check("abort_len_out", len_out, 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_quiet", o_we, 0);
        end
        check("abort_writes", exp_q.size(), 0);
        exp_q.delete();
        run_merge("after_abort", 4, 0, 0);

        // Random sorted tables with incidental shared keys
        for (int t = 0; t < 4; t++) begin
            gen_random(la, lb);
            run_merge("random", la, lb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
